// File: rtl/instr_fetch.sv
// Instruction fetch unit. It drives word addresses to a registered-read instruction memory
// and queues the returned {pc, instr} pairs in a skid FIFO toward decode.
module instr_fetch #(
  parameter int MEM_DEPTH = 32,
  parameter int RESET_PC  = 0,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_valid,
  input  logic        in_ready,
  input  logic        in_redirect,
  input  logic [31:0] in_target,
  output logic        done
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1) + 1;
  localparam logic [31:0]      PC_END   = 32'(MEM_DEPTH);
  localparam logic [31:0]      PC_START = 32'(RESET_PC);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  logic [31:0]      fetch_pc;
  logic             req_valid;
  logic [31:0]      req_pc;
  logic [31:0]      buf_pc    [BUF_DEPTH];
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic pop;
  logic push;
  logic in_range;
  logic has_credit;
  logic issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign mem_addr  = fetch_pc;
  assign out_valid = (fifo_count != '0);
  assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;

  // Credit counts the in-flight request as occupied so its data always has a slot.
  assign pop        = out_valid & in_ready;
  assign push       = req_valid & ~in_redirect;
  assign in_range   = (fetch_pc < PC_END);
  assign has_credit = (fifo_count + CNT_W'(req_valid)) < (CNT_W'(BUF_DEPTH) + CNT_W'(pop));
  assign issue      = ~in_redirect & in_range & has_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= PC_START;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (in_redirect) begin
      fetch_pc  <= in_target;
      req_valid <= 1'b0;
    end else if (issue) begin
      req_pc    <= fetch_pc;
      req_valid <= 1'b1;
      fetch_pc  <= fetch_pc + 32'd1;
    end else begin
      req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (in_redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= req_pc;
      buf_instr[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= ~in_range & ~req_valid & (fifo_count == '0);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The memory model returns instr[k] = k + 100 one
// cycle after the address is presented.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        in_ready = 1'b0;
  logic        in_redirect = 1'b0;
  logic [31:0] in_target = '0;
  logic        done;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.MEM_DEPTH(32), .RESET_PC(0), .BUF_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_valid(out_valid),
    .in_ready(in_ready),
    .in_redirect(in_redirect),
    .in_target(in_target),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem_addr + 32'd100;

  task automatic apply_reset;
    rst = 1'b1;
    in_ready = 1'b0;
    in_redirect = 1'b0;
    in_target = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_ready = 1'b0;
    in_redirect = 1'b0;
    #1;
    total++;
    if ({out_valid, done} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags got valid=%b done=%b want 0 0", out_valid, done); end
    total++;
    if ({out_pc, out_instr} !== 64'd0) begin bad++; $display("[TB] FAIL reset_outs got pc=%h instr=%h want 0 0", out_pc, out_instr); end
    total++;
    if (mem_addr !== 32'd0) begin bad++; $display("[TB] FAIL reset_addr got %h want 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, mem_addr} !== {1'b0, 32'd1}) begin bad++; $display("[TB] FAIL reset_e1 got valid=%b addr=%h want 0 1", out_valid, mem_addr); end
    @(negedge clk);
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd0, 32'd100}) begin bad++; $display("[TB] FAIL reset_e2 got valid=%b pc=%h instr=%h want 1 0 100", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_stream;
    logic exp_v;
    logic [31:0] exp_pc;
    apply_reset();
    in_ready = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      exp_v = (c >= 2) && (c <= 33);
      exp_pc = 32'(c - 2);
      total++;
      if (out_valid !== exp_v) begin bad++; $display("[TB] FAIL stream_valid c=%0d got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        total++;
        if ({out_pc, out_instr} !== {exp_pc, exp_pc + 32'd100}) begin bad++; $display("[TB] FAIL stream_data c=%0d got pc=%0d instr=%0d want pc=%0d", c, out_pc, out_instr, exp_pc); end
      end
      total++;
      if (done !== (c >= 35)) begin bad++; $display("[TB] FAIL stream_done c=%0d got %b want %b", c, done, (c >= 35)); end
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    in_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_first got valid=%b want 0", out_valid); end
      end else begin
        total++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd0, 32'd100}) begin bad++; $display("[TB] FAIL bp_hold c=%0d got valid=%b pc=%0d instr=%0d want 1 0 100", c, out_valid, out_pc, out_instr); end
        total++;
        if (mem_addr !== 32'd2) begin bad++; $display("[TB] FAIL bp_stall c=%0d got addr=%0d want 2", c, mem_addr); end
      end
    end
    in_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(1 + j), 32'(101 + j)}) begin bad++; $display("[TB] FAIL bp_resume j=%0d got valid=%b pc=%0d instr=%0d want pc=%0d", j, out_valid, out_pc, out_instr, 1 + j); end
    end
  endtask

  task automatic test_redirect;
    apply_reset();
    in_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({out_valid, out_pc} !== {1'b1, 32'd2}) begin bad++; $display("[TB] FAIL rd_pre got valid=%b pc=%0d want 1 2", out_valid, out_pc); end
    in_redirect = 1'b1;
    in_target = 32'd20;
    @(negedge clk);
    in_redirect = 1'b0;
    total++;
    if ({out_valid, mem_addr} !== {1'b0, 32'd20}) begin bad++; $display("[TB] FAIL rd_r1 got valid=%b addr=%0d want 0 20", out_valid, mem_addr); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_r2 got valid=%b want 0", out_valid); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(20 + j), 32'(120 + j)}) begin bad++; $display("[TB] FAIL rd_stream j=%0d got valid=%b pc=%0d instr=%0d want pc=%0d", j, out_valid, out_pc, out_instr, 20 + j); end
    end
  endtask

  task automatic test_redirect_oob;
    apply_reset();
    in_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_redirect = 1'b1;
    in_target = 32'd40;
    @(negedge clk);
    in_redirect = 1'b0;
    total++;
    if ({out_valid, done, mem_addr} !== {1'b0, 1'b0, 32'd40}) begin bad++; $display("[TB] FAIL oob_r1 got valid=%b done=%b addr=%0d want 0 0 40", out_valid, done, mem_addr); end
    @(negedge clk);
    total++;
    if ({out_valid, done} !== 2'b01) begin bad++; $display("[TB] FAIL oob_done got valid=%b done=%b want 0 1", out_valid, done); end
    @(negedge clk);
    total++;
    if ({done, mem_addr} !== {1'b1, 32'd40}) begin bad++; $display("[TB] FAIL oob_idle got done=%b addr=%0d want 1 40", done, mem_addr); end
    in_redirect = 1'b1;
    in_target = 32'd5;
    @(negedge clk);
    in_redirect = 1'b0;
    total++;
    if ({done, mem_addr} !== {1'b1, 32'd5}) begin bad++; $display("[TB] FAIL oob_back_r1 got done=%b addr=%0d want 1 5", done, mem_addr); end
    @(negedge clk);
    total++;
    if ({done, out_valid} !== 2'b00) begin bad++; $display("[TB] FAIL oob_clear got done=%b valid=%b want 0 0", done, out_valid); end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(5 + j), 32'(105 + j)}) begin bad++; $display("[TB] FAIL oob_stream j=%0d got valid=%b pc=%0d instr=%0d want pc=%0d", j, out_valid, out_pc, out_instr, 5 + j); end
    end
  endtask

  task automatic test_redirect_pop;
    int seen7;
    int seen8;
    seen7 = 0;
    seen8 = 0;
    apply_reset();
    in_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 10) in_redirect = 1'b0;
      if (out_valid && in_ready && out_pc == 32'd7) seen7++;
      if (out_valid && in_ready && out_pc == 32'd8) seen8++;
      if (c == 9) begin
        total++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd7, 32'd107}) begin bad++; $display("[TB] FAIL rp_head got valid=%b pc=%0d instr=%0d want 1 7 107", out_valid, out_pc, out_instr); end
        in_redirect = 1'b1;
        in_target = 32'd12;
      end
      if (c == 10 || c == 11) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rp_gap c=%0d got valid=%b want 0", c, out_valid); end
      end
      if (c >= 12) begin
        total++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(c), 32'(c + 100)}) begin bad++; $display("[TB] FAIL rp_stream c=%0d got valid=%b pc=%0d instr=%0d want pc=%0d", c, out_valid, out_pc, out_instr, c); end
      end
    end
    total++;
    if ({seen7, seen8} !== {32'd1, 32'd0}) begin bad++; $display("[TB] FAIL rp_count got seen7=%0d seen8=%0d want 1 0", seen7, seen8); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    in_ready = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if ({out_valid, out_pc} !== {1'b1, 32'd4}) begin bad++; $display("[TB] FAIL ar_pre got valid=%b pc=%0d want 1 4", out_valid, out_pc); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, done, out_pc, out_instr, mem_addr} !== {2'b00, 96'd0}) begin bad++; $display("[TB] FAIL ar_clear got valid=%b done=%b pc=%0d instr=%0d addr=%0d want all 0", out_valid, done, out_pc, out_instr, mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ar_e1 got valid=%b want 0", out_valid); end
    @(negedge clk);
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd0, 32'd100}) begin bad++; $display("[TB] FAIL ar_e2 got valid=%b pc=%0d instr=%0d want 1 0 100", out_valid, out_pc, out_instr); end
    in_redirect = 1'b1;
    in_target = 32'd40;
    @(negedge clk);
    in_redirect = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL ar_done_set got %b want 1", done); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({done, mem_addr} !== {1'b0, 32'd0}) begin bad++; $display("[TB] FAIL ar_done_clear got done=%b addr=%0d want 0 0", done, mem_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_oob();
    test_redirect_pop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
